result_uart_tx: RTL and testbench
=================================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868; clock cycles per UART bit (100 MHz / 115200 baud), legal range 2..65535.
REQ-002 Parameter START_ADDR, default 16'h0000; first data-memory byte address read out.
REQ-003 Parameter LENGTH, default 16384; number of bytes transmitted per run, legal range 1..65536-START_ADDR.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 finish_signal  input  1  level from data memory, high once the processor has finished writing the down-sampled image.
REQ-007 rd_en  output  1  data-memory read strobe, one cycle wide.
REQ-008 rd_addr  output  16  data-memory read address.
REQ-009 rd_data  input  8  data-memory read data, valid exactly 1 cycle after rd_en.
REQ-010 tx  output  1  UART serial line, idle high.
REQ-011 busy  output  1  high from run start until the last stop bit completes.
REQ-012 done  output  1  single-cycle pulse on the cycle the run completes.

Function
REQ-013 Run starts only on a rising edge of finish_signal (registered previous value 0, current 1) while in IDLE; rising edges while busy are ignored; a held-high level never restarts.
REQ-014 FSM states: IDLE, FETCH, WAIT, START, DATA, STOP; only legal transition order IDLE->FETCH->WAIT->START->DATA->STOP->(FETCH | IDLE).
REQ-015 FETCH: rd_en=1, rd_addr=START_ADDR+byte_count, lasts exactly 1 cycle.
REQ-016 WAIT: rd_data captured into an 8-bit shift register at end of cycle, lasts exactly 1 cycle.
REQ-017 START: tx=0 for exactly CLKS_PER_BIT cycles.
REQ-018 DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles; 3-bit bit index wraps 7->0 on exit.
REQ-019 STOP: tx=1 for exactly CLKS_PER_BIT cycles; then byte_count increments; if byte_count reaches LENGTH go to IDLE with done=1 for that single cycle, otherwise go to FETCH.
REQ-020 Inter-byte gap = 2 cycles (FETCH+WAIT) of tx=1; one byte frame = 10*CLKS_PER_BIT+2 cycles.
REQ-021 Baud counter is 16 bits, counts 0..CLKS_PER_BIT-1, and is cleared on every state entry.
REQ-022 byte_count is 17 bits so LENGTH=65536 does not overflow; rd_addr is the low 16 bits of the sum.
REQ-023 tx, busy, done, rd_en are registered outputs with no combinational path from inputs.
REQ-024 rd_en=0 in every state other than FETCH; rd_addr holds its last value.
REQ-025 busy=1 in every state other than IDLE; busy falls in the same cycle done pulses.

Reset
REQ-026 Reset values: state=IDLE, tx=1, busy=0, done=0, rd_en=0, rd_addr=START_ADDR, byte_count=0, baud counter=0, previous-finish register=0.
REQ-027 Reset asserted mid-frame aborts the run; tx=1 on the first cycle after reset is sampled; no done pulse is produced.
REQ-028 finish_signal already high when reset deasserts does not start a run; only a subsequent 0->1 transition does.

Structure
REQ-029 Shared package holds the FSM state enumeration, the default CLKS_PER_BIT, and the data-memory address width (16) and data width (8) constants.
REQ-030 One sub-module, uart_bit_timer: cycle counter with clear input and one-cycle tick output at CLKS_PER_BIT-1; the FSM instantiates it once.

Verification (CLKS_PER_BIT=4, START_ADDR=16'h0010, LENGTH=3)
REQ-031 Memory 0x10..0x12 = 8'hA5, 8'h3C, 8'hFF; raise finish_signal -> tx frames decode to A5, 3C, FF, each 40+2 cycles; done pulses once; rd_addr sequence 0x10, 0x11, 0x12.
REQ-032 Byte 8'hA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles.
REQ-033 finish_signal held high after done for 500 cycles -> no further rd_en, tx stays 1, busy stays 0.
REQ-034 Reset asserted during DATA bit 3 of the second byte -> tx=1 next cycle, busy=0, no done; a new 0->1 on finish_signal restarts from address 0x10.
REQ-035 finish_signal toggled 0->1 twice while busy -> exactly 3 bytes sent and one done pulse.
REQ-036 LENGTH=1, START_ADDR=16'hFFFF, mem[FFFF]=8'h81 -> single frame 81, rd_addr=FFFF, done after 42 cycles from start.

Source files
------------

// File: rtl/result_uart_tx_pkg.sv
// Shared constants and FSM state encoding for the result UART transmitter.
package result_uart_tx_pkg;

  localparam int unsigned ADDR_W           = 16;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned BAUD_W           = 16;
  localparam int unsigned COUNT_W          = 17;
  localparam int unsigned CLKS_PER_BIT_DEF = 868;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

endpackage

// File: rtl/result_uart_tx_if.sv
// Data-memory read port, finish flag and UART outputs of result_uart_tx.
//   master : transmitter side (drives rd_en/rd_addr/tx/busy/done)
//   slave  : memory / environment side (drives finish_signal/rd_data)
interface result_uart_tx_if;
  import result_uart_tx_pkg::*;

  logic              finish_signal;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    input  finish_signal, rd_data,
    output rd_en, rd_addr, tx, busy, done
  );

  modport slave (
    output finish_signal, rd_data,
    input  rd_en, rd_addr, tx, busy, done
  );

endinterface

// File: rtl/result_uart_tx_uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
//   clk, reset : clock, synchronous active-high reset
//   clear_i    : restart the count at 0 on the next cycle
//   tick_c_o   : combinational, high while the count is CLKS_PER_BIT-1
module uart_bit_timer
  import result_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_c_o
);

  logic [BAUD_W-1:0] cnt_q, cnt_d;

  assign tick_c_o = (cnt_q == BAUD_W'(CLKS_PER_BIT - 1));

  // Wrap on tick so consecutive bits in one state are timed back to back.
  always_comb begin
    cnt_d = BAUD_W'(cnt_q + 1'b1);
    if (clear_i || tick_c_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/result_uart_tx.sv
// Streams LENGTH bytes from data memory (starting at START_ADDR) out of a
// UART (8N1, LSB first) once the processor raises finish_signal.
//   clk, reset : clock, synchronous active-high reset
//   bus        : finish_signal/rd_data in; rd_en/rd_addr/tx/busy/done out
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int unsigned       CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter logic [ADDR_W-1:0] START_ADDR   = 16'h0000,
  parameter int unsigned       LENGTH       = 16384
) (
  input  logic                   clk,
  input  logic                   reset,
  result_uart_tx_if.master       bus
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic               fin_prev_q;
  logic               armed_q;
  logic               start_c;
  logic               tick_c;
  logic               state_change_c;

  // armed_q blocks a start until finish_signal has been seen low after reset,
  // so a level already high when reset releases is not taken as an edge.
  assign start_c        = bus.finish_signal && !fin_prev_q && armed_q;
  assign state_change_c = (state_d != state_q);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_change_c),
    .tick_c_o (tick_c)
  );

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d    = ST_FETCH;
          byte_cnt_d = '0;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        shreg_d = bus.rd_data;
        state_d = ST_START;
      end
      ST_START: begin
        if (tick_c) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else                   shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          byte_cnt_d = COUNT_W'(byte_cnt_q + 1'b1);
          if (byte_cnt_d == COUNT_W'(LENGTH)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with state_q.
    busy_d    = (state_d != ST_IDLE);
    rd_en_d   = (state_d == ST_FETCH);
    rd_addr_d = rd_en_d ? ADDR_W'(COUNT_W'(START_ADDR) + byte_cnt_d) : rd_addr_q;
    tx_d      = 1'b1;
    if (state_d == ST_START)     tx_d = 1'b0;
    else if (state_d == ST_DATA) tx_d = shreg_d[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      rd_addr_q  <= START_ADDR;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      fin_prev_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      rd_addr_q  <= rd_addr_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      fin_prev_q <= bus.finish_signal;
      armed_q    <= armed_q || !bus.finish_signal;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx: two instances (3-byte run at 0x0010,
// 1-byte run at 0xFFFF), a memory model, and a UART receiver that decodes tx.
module tb_result_uart_tx;

  localparam int          CPB     = 4;
  localparam int          FRAME   = 10 * CPB + 2;
  localparam logic [15:0] START_A = 16'h0010;
  localparam int          LEN_A   = 3;
  localparam logic [15:0] START_B = 16'hFFFF;
  localparam int          LEN_B   = 1;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  result_uart_tx_if ifa ();
  result_uart_tx_if ifb ();

  result_uart_tx #(.CLKS_PER_BIT(CPB), .START_ADDR(START_A), .LENGTH(LEN_A)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa.master));
  result_uart_tx #(.CLKS_PER_BIT(CPB), .START_ADDR(START_B), .LENGTH(LEN_B)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb.master));

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-instance memory model, UART receiver and scoreboard.
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int          LEN   = (g == 0) ? LEN_A : LEN_B;
    localparam logic [15:0] SADDR = (g == 0) ? START_A : START_B;
    wire        tx_w      = (g == 0) ? ifa.tx      : ifb.tx;
    wire        busy_w    = (g == 0) ? ifa.busy    : ifb.busy;
    wire        done_w    = (g == 0) ? ifa.done    : ifb.done;
    wire        rd_en_w   = (g == 0) ? ifa.rd_en   : ifb.rd_en;
    wire [15:0] rd_addr_w = (g == 0) ? ifa.rd_addr : ifb.rd_addr;
    wire        rst_w     = (g == 0) ? rst_a       : rst_b;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_data;
    logic [7:0]  exp_q [$];
    logic [15:0] addr_q [$];
    bit          armed;
    int          done_cnt;

    initial begin
      bit          pend_en;
      logic [15:0] pend_addr;
      int          rx_pos;
      logic [9:0]  bits;
      bit          bit_ok;
      longint      cyc;
      longint      busy_rise;
      longint      last_start;
      int          frames;
      bit          busy_prev;
      logic [7:0]  e8;
      logic [15:0] e16;
      rd_data = '0; armed = 0; done_cnt = 0; pend_en = 0; pend_addr = '0;
      rx_pos = -1; bits = '0; bit_ok = 1; cyc = 0; busy_rise = 0;
      last_start = 0; frames = 0; busy_prev = 0;
      forever begin
        @(posedge clk);
        #1;
        cyc++;
        // Read data appears exactly one cycle after rd_en; junk otherwise.
        rd_data   = pend_en ? mem[pend_addr] : 8'($urandom);
        pend_en   = rd_en_w;
        pend_addr = rd_addr_w;
        if (rst_w) begin
          chk(tx_w && !busy_w && !done_w && !rd_en_w && rd_addr_w == SADDR, "reset_outputs",
              {tx_w, busy_w, done_w, rd_en_w, rd_addr_w}, {4'b1000, SADDR});
          exp_q.delete(); addr_q.delete();
          armed = 0; rx_pos = -1; pend_en = 0; busy_prev = 0;
        end else begin
          if (busy_w && !busy_prev) begin
            chk(armed, "run_start_expected", 1, armed);
            armed = 0; busy_rise = cyc; frames = 0;
          end
          if (!busy_w && busy_prev && !done_w) chk(0, "busy_fell_without_done", 0, 1);
          chk(busy_w || tx_w, "tx_idle_high", tx_w, 1);
          if (rd_en_w) begin
            if (addr_q.size() == 0) chk(0, "unexpected_rd_en", rd_addr_w, 0);
            else begin
              e16 = addr_q.pop_front();
              chk(rd_addr_w == e16, "rd_addr", rd_addr_w, e16);
            end
          end
          if (rx_pos < 0 && !tx_w) begin
            rx_pos = 0; bit_ok = 1;
            if (frames == 0) chk(cyc - busy_rise == 2, "first_frame_latency", cyc - busy_rise, 2);
            else             chk(cyc - last_start == FRAME, "frame_period", cyc - last_start, FRAME);
            last_start = cyc; frames++;
          end
          if (rx_pos >= 0) begin
            if (rx_pos % CPB == 0)               bits[rx_pos / CPB] = tx_w;
            else if (tx_w != bits[rx_pos / CPB]) bit_ok = 0;
            rx_pos++;
            if (rx_pos == 10 * CPB) begin
              rx_pos = -1;
              chk(bit_ok && !bits[0] && bits[9], "frame_shape", {bit_ok, bits}, 11'h600);
              if (exp_q.size() == 0) chk(0, "unexpected_frame", bits[8:1], 0);
              else begin
                e8 = exp_q.pop_front();
                chk(bits[8:1] == e8, "frame_byte", bits[8:1], e8);
              end
            end
          end
          if (done_w) begin
            done_cnt++;
            chk(!busy_w, "busy_low_at_done", busy_w, 0);
            chk(cyc - busy_rise == LEN * FRAME, "run_cycles", cyc - busy_rise, LEN * FRAME);
            chk(exp_q.size() == 0 && rx_pos < 0, "all_bytes_sent", exp_q.size(), 0);
          end
          busy_prev = busy_w;
        end
      end
    end
  end

  assign ifa.rd_data = mon[0].rd_data;
  assign ifb.rd_data = mon[1].rd_data;

  task automatic set_fin(input int g, input logic v);
    if (g == 0) ifa.finish_signal = v;
    else        ifb.finish_signal = v;
  endtask

  function automatic int done_of(input int g);
    return (g == 0) ? mon[0].done_cnt : mon[1].done_cnt;
  endfunction

  // Queue the expected bytes/addresses of one run, then raise finish_signal.
  task automatic start_run(input int g);
    set_fin(g, 1'b0);
    repeat (2) @(negedge clk);
    if (g == 0) begin
      for (int i = 0; i < LEN_A; i++) begin
        mon[0].exp_q.push_back(mon[0].mem[16'(START_A + i)]);
        mon[0].addr_q.push_back(16'(START_A + i));
      end
      mon[0].armed = 1;
    end else begin
      for (int i = 0; i < LEN_B; i++) begin
        mon[1].exp_q.push_back(mon[1].mem[16'(START_B + i)]);
        mon[1].addr_q.push_back(16'(START_B + i));
      end
      mon[1].armed = 1;
    end
    set_fin(g, 1'b1);
  endtask

  task automatic wait_done(input int g, input int target);
    int n;
    n = 0;
    while (done_of(g) < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(done_of(g) == target, "done_wait", done_of(g), target);
  endtask

  task automatic fill_a();
    for (int i = 0; i < LEN_A; i++) mon[0].mem[16'(START_A + i)] = 8'($urandom);
  endtask

  initial begin
    int seen;
    int n;
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.finish_signal = 1'b0; ifb.finish_signal = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Directed bytes, including A5 bit pattern.
    mon[0].mem[16'h0010] = 8'hA5;
    mon[0].mem[16'h0011] = 8'h3C;
    mon[0].mem[16'h0012] = 8'hFF;
    start_run(0);
    wait_done(0, 1);

    // Held-high finish must not restart.
    repeat (500) @(negedge clk);
    chk(mon[0].done_cnt == 1 && !ifa.busy, "held_high_no_restart", mon[0].done_cnt, 1);

    // Random runs; run 1 gets two extra 0->1 toggles while busy.
    for (int r = 0; r < 3; r++) begin
      fill_a();
      start_run(0);
      if (r == 1) begin
        repeat (20) @(negedge clk); set_fin(0, 1'b0);
        repeat (3)  @(negedge clk); set_fin(0, 1'b1);
        repeat (30) @(negedge clk); set_fin(0, 1'b0);
        repeat (3)  @(negedge clk); set_fin(0, 1'b1);
      end
      wait_done(0, 2 + r);
      repeat (60) @(negedge clk);
    end
    chk(mon[0].done_cnt == 4, "done_count_after_runs", mon[0].done_cnt, 4);

    // Reset in DATA bit 3 of the second byte (bit 3 forced to 0).
    fill_a();
    mon[0].mem[16'h0011] = 8'($urandom) & 8'hF7;
    start_run(0);
    seen = 0; n = 0;
    while (seen < 2 && n < 500) begin
      @(negedge clk);
      n++;
      if (ifa.rd_en) seen++;
    end
    chk(seen == 2, "second_fetch_seen", seen, 2);
    repeat (19) @(negedge clk);
    chk(ifa.busy && !ifa.tx, "in_data_bit3", {ifa.busy, ifa.tx}, 2'b10);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (60) @(negedge clk);
    chk(mon[0].done_cnt == 4 && !ifa.busy, "no_done_after_abort", mon[0].done_cnt, 4);
    fill_a();
    start_run(0);
    wait_done(0, 5);

    // Finish rising during reset must not start a run.
    repeat (10) @(negedge clk);
    set_fin(0, 1'b0);
    rst_a = 1'b1;
    @(negedge clk);
    set_fin(0, 1'b1);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (100) @(negedge clk);
    chk(mon[0].done_cnt == 5 && !ifa.busy, "no_start_from_reset_level", mon[0].done_cnt, 5);
    fill_a();
    start_run(0);
    wait_done(0, 6);

    // Single byte at the top of the address space.
    mon[1].mem[16'hFFFF] = 8'h81;
    start_run(1);
    wait_done(1, 1);
    repeat (50) @(negedge clk);
    chk(mon[1].done_cnt == 1, "b_single_done", mon[1].done_cnt, 1);
    chk(mon[0].exp_q.size() == 0 && mon[0].addr_q.size() == 0 && mon[1].exp_q.size() == 0,
        "queues_drained", mon[0].exp_q.size() + mon[0].addr_q.size() + mon[1].exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
